joy_path_gen: RTL

JOY_PATH_GEN -- requirements
Module: joy_path_gen

---
 rtl/joy_path_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/joy_path_gen.sv
// Joystick path generator: walks cur_x/cur_y one unit per step toward a
// latched target, resolving y before x, paced by STEP_DIV clock cycles.
module joy_path_gen #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tgt_x,
  input  logic [7:0] tgt_y,
  input  logic       home,
  output logic [1:0] positions,
  output logic       step,
  output logic       busy,
  output logic       done,
  output logic [7:0] cur_x,
  output logic [7:0] cur_y
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEP_DIV - 1);

  localparam logic [1:0] CODE_UP    = 2'b00;
  localparam logic [1:0] CODE_DOWN  = 2'b01;
  localparam logic [1:0] CODE_LEFT  = 2'b10;
  localparam logic [1:0] CODE_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    tx_q, tx_n;
  logic [7:0]    ty_q, ty_n;
  logic [7:0]    cx_n, cy_n;
  logic [1:0]    pos_n;
  logic          step_n, busy_n, done_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      positions <= CODE_UP;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      tx_q      <= tx_n;
      ty_q      <= ty_n;
      cur_x     <= cx_n;
      cur_y     <= cy_n;
      positions <= pos_n;
      step      <= step_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    tx_n    = tx_q;
    ty_n    = ty_q;
    cx_n    = cur_x;
    cy_n    = cur_y;
    pos_n   = positions;
    step_n  = 1'b0;
    done_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_n    = tgt_x;
          ty_n    = tgt_y;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else if (cur_y != ty_q) begin
          // Comparison-selected direction cannot overshoot, so no wrap is possible
          step_n = 1'b1;
          cnt_n  = CNT_LOAD;
          if (ty_q > cur_y) begin
            pos_n = CODE_UP;
            cy_n  = cur_y + 8'd1;
          end else begin
            pos_n = CODE_DOWN;
            cy_n  = cur_y - 8'd1;
          end
        end else if (cur_x != tx_q) begin
          step_n = 1'b1;
          cnt_n  = CNT_LOAD;
          if (tx_q > cur_x) begin
            pos_n = CODE_RIGHT;
            cx_n  = cur_x + 8'd1;
          end else begin
            pos_n = CODE_LEFT;
            cx_n  = cur_x - 8'd1;
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // home aborts any move and overrides start
    if (home) begin
      state_n = IDLE;
      cnt_n   = '0;
      cx_n    = '0;
      cy_n    = '0;
      step_n  = 1'b0;
      done_n  = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule
